i2c_seq_writer: RTL
===================

// Module: i2c_seq_writer
// PURPOSE
// Parametrised I2C master that writes a table of N_CMD commands of BYTES_PER_CMD bytes each to a slave codec.
// Each command is one transaction: START, bytes MSB-first with ACK slots, STOP.
// Generalises the fixed WM8731 initializer: configurable table, SCL rate, real ACK checking with retry, error report.
// Sits between top-level reset/start control and the open-drain I2C pads.
// PARAMETERS
// N_CMD          10  number of commands in the table
// BYTES_PER_CMD  3   bytes per command (address byte included)
// CLK_DIV        4   i_clk cycles per SCL quarter-period (>=2)
// MAX_RETRY      3   re-attempts of a NACKed command before error (0 = no retry)
// PORTS
// i_clk       in   1                          system clock
// i_rst_n     in   1                          asynchronous active-low reset
// i_start     in   1                          begin sequence; 1-cycle pulse or level
// i_cmd_table in   N_CMD*BYTES_PER_CMD*8      cmd k byte b at [(k*BYTES_PER_CMD+b)*8 +: 8], b=0 sent first
// i_sda       in   1                          SDA pad read-back for ACK sampling
// o_sclk      out  1                          SCL
// o_sdat      out  1                          SDA drive value, valid when o_oen=1
// o_oen       out  1                          1 = drive SDA, 0 = release (ACK slot)
// o_busy      out  1                          sequence in progress
// o_finished  out  1                          all commands ACKed; held until next accepted start
// o_error     out  1                          command failed after MAX_RETRY retries; held until next start
// o_err_idx   out  $clog2(N_CMD)              index of failing command, valid with o_error
// BEHAVIOUR
// - Reset (async): o_sclk=1, o_sdat=1, o_oen=1, o_busy=0, o_finished=0, o_error=0, o_err_idx=0, FSM=IDLE, counters 0.
// - Tick: one-cycle pulse every CLK_DIV clocks, counter free-running only while busy and cleared in IDLE.
// - Every FSM slot (START, data bit, ACK, STOP, GAP) is 4 ticks, quarters Q0..Q3.
// - IDLE: i_start sampled high -> busy=1, cmd=0, retry=0, clear finished/error; i_start while busy ignored.
// - START: Q0 SCL=1,SDA=1; Q1 SDA=0; Q2/Q3 SCL=0.
// - BIT: Q0 set SDA = current bit (SCL low); Q1,Q2 SCL=1; Q3 SCL=0; SDA never changes while SCL=1.
// - ACK: oen=0 whole slot; SCL as BIT; i_sda sampled on Q2; 0 = ACK, 1 = NACK.
// - After ACK: next byte of command, or STOP after last byte.
// - NACK: go to STOP at once; then retry++ and restart the same command at byte 0.
// - If retry already = MAX_RETRY: o_error=1, o_err_idx=cmd, then IDLE.
// - STOP: Q0 SDA=0 (SCL low); Q1 SCL=1; Q2 SDA=1; Q3 hold.
// - GAP: bus idle (SCL=SDA=1, oen=1) for one slot; then next cmd with retry=0, or DONE.
// - DONE: o_finished=1, busy=0, return to IDLE; finished/error stay high until next accepted start.
// - Timing, all ACKed: o_finished rises N_CMD*(9*BYTES_PER_CMD+3)*4*CLK_DIV cycles after the i_start sample edge.
// - Mid-operation reset: outputs return to reset values immediately; no STOP is generated.
// - Widths: bit counter $clog2(8), byte counter $clog2(BYTES_PER_CMD+1), cmd counter $clog2(N_CMD+1).
// - Counters never wrap past their terminal values.
// STRUCTURE
// - Package i2c_pkg: state enum (IDLE, START, BIT, ACK, STOP, GAP, DONE).
// - i2c_pkg also holds quarter-phase enum and WM8731_INIT_TABLE constant (10x24-bit default codec setup).
// - Sub-module i2c_tick_gen (CLK_DIV divider, enable/clear, tick pulse).
// - The main FSM stays in this file.
// TESTING
// 1. Default params, slave model ACKs all, WM8731_INIT_TABLE
//    -> 10 transactions, byte 0 = 0x34 each.
//    -> o_finished after 10*30*16 = 4800 cycles.
// 2. Bus monitor over all runs -> no SDA edge while SCL=1 except START (fall) and STOP (rise).
// 3. Slave NACKs cmd 4 once -> STOP, cmd 4 resent from byte 0, sequence finishes, o_error=0.
// 4. Slave NACKs cmd 7 always, MAX_RETRY=3
//    -> 4 attempts, then o_error=1, o_err_idx=7, o_finished=0, busy=0.
// 5. Assert i_rst_n low mid-byte of cmd 2
//    -> o_sclk=1, o_sdat=1, o_oen=1 same cycle; new i_start replays from cmd 0.
// 6. N_CMD=2, BYTES_PER_CMD=2, CLK_DIV=2; i_start pulsed again while busy
//    -> ignored; o_finished after 2*21*8 = 336 cycles.

Source files
------------

// File: rtl/i2c_seq_writer_pkg.sv
// Shared types for the I2C command-table writer: FSM states, SCL quarter phases,
// and the default WM8731 codec bring-up table.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    GAP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam int WM8731_N_CMD = 10;

  // Each entry is {data, reg_addr<<1 | data[8], dev_addr}; cmd 0 sits in the low bits.
  localparam logic [WM8731_N_CMD*24-1:0] WM8731_INIT_TABLE = {
    24'h01_12_34,  // active
    24'h01_0E_34,  // digital audio interface format
    24'h00_0C_34,  // power down control: all on
    24'h00_0A_34,  // digital path
    24'h12_08_34,  // analog path
    24'h79_06_34,  // right headphone out
    24'h79_04_34,  // left headphone out
    24'h17_02_34,  // right line in
    24'h17_00_34,  // left line in
    24'h00_1E_34   // reset
  };

endpackage

// File: rtl/i2c_seq_writer_tick_gen.sv
// Divides i_clk by CLK_DIV into a one-cycle tick that paces SCL quarter-periods.
// Counts only while enabled; clearing holds the phase at zero.
module i2c_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/i2c_seq_writer.sv
// I2C master that writes N_CMD commands of BYTES_PER_CMD bytes, one START..STOP each,
// retrying NACKed commands up to MAX_RETRY times before flagging an error.
module i2c_seq_writer
  import i2c_pkg::*;
#(
  parameter int N_CMD         = 10,
  parameter int BYTES_PER_CMD = 3,
  parameter int CLK_DIV       = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_start,
  input  logic [N_CMD*BYTES_PER_CMD*8-1:0]    i_cmd_table,
  input  logic                                i_sda,
  output logic                                o_sclk,
  output logic                                o_sdat,
  output logic                                o_oen,
  output logic                                o_busy,
  output logic                                o_finished,
  output logic                                o_error,
  output logic [((N_CMD > 1) ? $clog2(N_CMD) : 1)-1:0] o_err_idx
);

  localparam int BW = $clog2(BYTES_PER_CMD + 1);
  localparam int CW = $clog2(N_CMD + 1);
  localparam int EW = (N_CMD > 1) ? $clog2(N_CMD) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_CMD - 1);
  localparam logic [CW-1:0] CMD_END   = CW'(N_CMD);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t         state, state_nxt;
  quarter_t       q, q_nxt;
  logic [2:0]     bit_cnt, bit_nxt;
  logic [BW-1:0]  byte_cnt, byte_nxt;
  logic [CW-1:0]  cmd_cnt, cmd_nxt;
  logic [RW-1:0]  retry, retry_nxt;
  logic [EW-1:0]  err_idx, err_idx_nxt;
  logic           nack, nack_nxt, busy, busy_nxt;
  logic           finished, fin_nxt, error, err_nxt;
  logic           tick;
  logic [1:0]     sda_sync;
  logic [7:0]     cur_byte;
  int             flat;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en      (busy),
    .clr     (state == IDLE),
    .tick    (tick)
  );

  assign o_busy     = busy;
  assign o_finished = finished;
  assign o_error    = error;
  assign o_err_idx  = err_idx;

  // Pad read-back is asynchronous to i_clk; two flops before the ACK sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sda_sync <= 2'b11;
    else          sda_sync <= {sda_sync[0], i_sda};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;  q <= Q0;  bit_cnt <= '0;  byte_cnt <= '0;  cmd_cnt <= '0;
      retry <= '0;  err_idx <= '0;  nack <= 1'b0;  busy <= 1'b0;
      finished <= 1'b0;  error <= 1'b0;
    end else begin
      state <= state_nxt;  q <= q_nxt;  bit_cnt <= bit_nxt;  byte_cnt <= byte_nxt;
      cmd_cnt <= cmd_nxt;  retry <= retry_nxt;  err_idx <= err_idx_nxt;  nack <= nack_nxt;
      busy <= busy_nxt;  finished <= fin_nxt;  error <= err_nxt;
    end
  end

  always_comb begin
    flat     = int'(cmd_cnt) * BYTES_PER_CMD + int'(byte_cnt);
    cur_byte = '0;
    for (int k = 0; k < N_CMD * BYTES_PER_CMD; k++) begin
      if (k == flat) cur_byte = i_cmd_table[k*8 +: 8];
    end
  end

  always_comb begin
    state_nxt = state;  q_nxt = q;  bit_nxt = bit_cnt;  byte_nxt = byte_cnt;
    cmd_nxt = cmd_cnt;  retry_nxt = retry;  err_idx_nxt = err_idx;  nack_nxt = nack;
    busy_nxt = busy;  fin_nxt = finished;  err_nxt = error;
    o_sclk = 1'b1;  o_sdat = 1'b1;  o_oen = 1'b1;

    // SDA only moves in quarters where SCL is low, except the START fall and STOP rise.
    case (state)
      START: begin o_sclk = (q == Q0) || (q == Q1); o_sdat = (q == Q0); end
      BIT:   begin o_sclk = (q == Q1) || (q == Q2); o_sdat = cur_byte[3'd7 - bit_cnt]; end
      ACK:   begin o_sclk = (q == Q1) || (q == Q2); o_oen = 1'b0; end
      STOP:  begin o_sclk = (q != Q0); o_sdat = (q == Q2) || (q == Q3); end
      default: ;
    endcase

    if (state == IDLE) begin
      if (i_start) begin
        state_nxt = START;  q_nxt = Q0;  busy_nxt = 1'b1;  cmd_nxt = '0;  retry_nxt = '0;
        bit_nxt = '0;  byte_nxt = '0;  nack_nxt = 1'b0;  fin_nxt = 1'b0;  err_nxt = 1'b0;
        err_idx_nxt = '0;
      end
    end else if (state == DONE) begin
      state_nxt = IDLE;
    end else if (tick) begin
      q_nxt = quarter_t'(q + 2'd1);
      if (state == ACK && q == Q2 && sda_sync[1]) nack_nxt = 1'b1;
      if (q == Q3) begin
        case (state)
          START: begin state_nxt = BIT; bit_nxt = '0; byte_nxt = '0; end
          BIT: begin
            if (bit_cnt == 3'd7) begin bit_nxt = '0; state_nxt = ACK; end
            else bit_nxt = bit_cnt + 3'd1;
          end
          ACK: begin
            if (nack || byte_cnt == LAST_BYTE) state_nxt = STOP;
            else begin byte_nxt = byte_cnt + 1'b1; state_nxt = BIT; end
          end
          STOP: begin
            if (!nack) begin
              cmd_nxt = cmd_cnt + 1'b1;  retry_nxt = '0;  state_nxt = GAP;
            end else if (retry == RETRY_MAX) begin
              err_nxt = 1'b1;  err_idx_nxt = cmd_cnt[EW-1:0];  busy_nxt = 1'b0;
              nack_nxt = 1'b0;  state_nxt = IDLE;
            end else begin
              retry_nxt = retry + 1'b1;  state_nxt = GAP;
            end
          end
          GAP: begin
            nack_nxt = 1'b0;  byte_nxt = '0;
            if (cmd_cnt == CMD_END) begin fin_nxt = 1'b1; busy_nxt = 1'b0; state_nxt = DONE; end
            else state_nxt = START;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

endmodule
